blueintegral_matmul_seq: RTL and testbench

//   Sequencer wrapped around the 2x2 binary matrix-multiply datapath
//   (blueintegral_mat_mult).
//   - Loads operand matrices A and B one nibble at a time over a narrow command bus.
//   - Issues the multiply and registers the 8-bit product (four 2-bit entries).
//   - Optionally iterates the multiply N times, feeding back a boolean-reduced result as the next A.
//   - Sits between the chip I/O pins and the combinational multiplier.
//

---
 rtl/blueintegral_matmul_seq.sv | 168 ++++++++++++++++
 tb/tb_blueintegral_matmul_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blueintegral_matmul_seq.sv
// rtl/blueintegral_matmul_seq.sv - command sequencer around the 2x2 binary matrix multiplier (optional MATSEQ_CHAIN_EN iteration)

// 2x2 binary matrix product; each entry is an unsigned sum in 0..2
module blueintegral_mat_mult (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);
   // entry order in each nibble is {m00,m01,m10,m11}
   always_comb begin
      o_p[7:6] = {1'b0, i_a[3] & i_b[3]} + {1'b0, i_a[2] & i_b[1]};
      o_p[5:4] = {1'b0, i_a[3] & i_b[2]} + {1'b0, i_a[2] & i_b[0]};
      o_p[3:2] = {1'b0, i_a[1] & i_b[3]} + {1'b0, i_a[0] & i_b[1]};
      o_p[1:0] = {1'b0, i_a[1] & i_b[2]} + {1'b0, i_a[0] & i_b[0]};
   end
endmodule

module blueintegral_matmul_seq #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       cmd,
   input  logic [3:0]       data_in,
   input  logic [CNT_W-1:0] count,
   output logic [7:0]       result,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam logic [1:0] CMD_NOP    = 2'b00;
   localparam logic [1:0] CMD_LOAD_A = 2'b01;
   localparam logic [1:0] CMD_LOAD_B = 2'b10;
   localparam logic [1:0] CMD_START  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_a_vld;
   logic       r_b_vld;
   logic [7:0] r_result;
   logic       r_err;
   logic [3:0] w_w;
   logic [7:0] w_prod;
   logic       w_last;
   logic       w_ld_a;
   logic       w_ld_b;
   logic       w_go;
   logic       w_fin;
   logic       w_iter;
   logic       w_err_set;

`ifdef MATSEQ_CHAIN_EN
   logic [3:0]       r_w;
   logic [CNT_W-1:0] r_rem;
   assign w_w    = r_w;
   assign w_last = (r_rem <= CNT_W'(1));
`else
   // single pass: the working operand is simply A, and count has no effect
   logic w_unused_sig;
   assign w_w          = r_a;
   assign w_last       = 1'b1;
   assign w_unused_sig = ^{count, w_iter};
`endif

   blueintegral_mat_mult u_mat_mult (
      .i_a (w_w),
      .i_b (r_b),
      .o_p (w_prod)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state, status outputs and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_ld_a      = 1'b0;
      w_ld_b      = 1'b0;
      w_go        = 1'b0;
      w_fin       = 1'b0;
      w_iter      = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_MUL: begin
            busy = 1'b1;
            // commands here are refused but never disturb the running multiply
            if (cmd != CMD_NOP) w_err_set = 1'b1;
            if (w_last) begin
               w_fin       = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_iter = 1'b1;
            end
         end
         default: begin
            // IDLE and DONE accept commands identically
            done        = (r_state == S_DONE);
            w_state_nxt = S_IDLE;
            case (cmd)
               CMD_LOAD_A: w_ld_a = 1'b1;
               CMD_LOAD_B: w_ld_b = 1'b1;
               CMD_START: begin
                  if (r_a_vld && r_b_vld) begin
                     w_go        = 1'b1;
                     w_state_nxt = S_MUL;
                  end else begin
                     w_err_set = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      endcase
   end

   // operand, result and error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= 4'h0;
         r_b      <= 4'h0;
         r_a_vld  <= 1'b0;
         r_b_vld  <= 1'b0;
         r_result <= 8'h00;
         r_err    <= 1'b0;
      end else begin
         if (w_ld_a) begin
            r_a     <= data_in;
            r_a_vld <= 1'b1;
         end
         if (w_ld_b) begin
            r_b     <= data_in;
            r_b_vld <= 1'b1;
         end
         if (w_fin)     r_result <= w_prod;
         if (w_err_set) r_err    <= 1'b1;
      end
   end

`ifdef MATSEQ_CHAIN_EN
   // working copy of A and remaining-iteration counter; A itself is never touched
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w   <= 4'h0;
         r_rem <= '0;
      end else if (w_go) begin
         r_w   <= r_a;
         r_rem <= (count == '0) ? CNT_W'(1) : count;
      end else if (w_iter) begin
         // boolean reduction: any nonzero sum becomes 1
         r_w   <= {|w_prod[7:6], |w_prod[5:4], |w_prod[3:2], |w_prod[1:0]};
         r_rem <= r_rem - CNT_W'(1);
      end
   end
`endif

   assign result = r_result;
   assign err    = r_err;

endmodule

// File: tb/tb_blueintegral_matmul_seq.sv
// tb/tb_blueintegral_matmul_seq.sv - scoreboard bench for blueintegral_matmul_seq
module tb_blueintegral_matmul_seq;
   localparam logic [1:0] NOP = 2'b00, LDA = 2'b01, LDB = 2'b10, GO = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] cmd;
   logic [3:0] data_in;
   logic [3:0] count;
   logic [7:0] result;
   logic       busy;
   logic       done;
   logic       err;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] sb[$];

   blueintegral_matmul_seq #(.CNT_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .cmd     (cmd),
      .data_in (data_in),
      .count   (count),
      .result  (result),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mm(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] r;
      int         s;
      r = 8'h00;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int k = 0; k < 2; k++)
               s += int'(a[3 - (2*i + k)] & b[3 - (2*k + j)]);
            r[7 - 2*(2*i + j) -: 2] = s[1:0];
         end
      return r;
   endfunction

   function automatic logic [7:0] chain(input logic [3:0] a, input logic [3:0] b, input int n);
      logic [3:0] w;
      logic [7:0] p;
      w = a;
      for (int it = 1; it < n; it++) begin
         p = mm(w, b);
         for (int e = 0; e < 4; e++) w[3 - e] = (p[7 - 2*e -: 2] != 2'd0);
      end
      return mm(w, b);
   endfunction

   function automatic int nexp(input int c);
`ifdef MATSEQ_CHAIN_EN
      return (c == 0) ? 1 : c;
`else
      return 1;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] c, input logic [3:0] d, input logic [3:0] n);
      cmd     = c;
      data_in = d;
      count   = n;
      tick();
      cmd     = NOP;
   endtask

   // called in the cycle after START; returns in the DONE cycle
   task automatic wait_done(input string tag, input int n_exp);
      int         busy_cyc = 0;
      bit         got = 0;
      logic [7:0] exp;
      for (int i = 0; i < 64 && !got; i++) begin
         if (busy) busy_cyc++;
         tick();
         cmd = NOP;
         if (done) got = 1;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n_exp));
      if (got && sb.size() > 0) begin
         exp = sb.pop_front();
         chk({tag, "_result"}, 32'(result), 32'(exp));
      end
   endtask

   initial begin
      logic [3:0] ra, rb, rc;
      bit         saw;
      cmd = NOP; data_in = 4'h0; count = 4'h0; reset = 1'b1;
      tick(); tick();
      chk("rst_result", 32'(result), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset = 1'b0;

      issue(LDA, 4'b1011, 4'd0);
      issue(LDB, 4'b0110, 4'd0);
      issue(GO, 4'h0, 4'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      sb.push_back(8'h15);
      wait_done("t1", 1);
      tick();
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_hold", 32'(result), 32'h15);

      issue(LDA, 4'b1111, 4'd0);
      issue(LDB, 4'b1111, 4'd0);
      issue(GO, 4'h0, 4'd1);
      sb.push_back(8'hAA);
      wait_done("t2a", 1);
      issue(LDB, 4'b1001, 4'd0);
      issue(GO, 4'h0, 4'd1);
      sb.push_back(8'h55);
      wait_done("t2b", 1);
      chk("t2_err", 32'(err), 32'd0);

      reset = 1'b1; tick(); reset = 1'b0;
      issue(LDA, 4'b0101, 4'd0);
      issue(GO, 4'h0, 4'd1);
      chk("t3_err", 32'(err), 32'd1);
      saw = 0;
      for (int i = 0; i < 5; i++) begin tick(); saw |= done; end
      chk("t3_no_done", 32'(saw), 32'd0);
      chk("t3_result", 32'(result), 32'h00);
      chk("t3_busy", 32'(busy), 32'd0);

      reset = 1'b1; tick(); reset = 1'b0;
      issue(LDA, 4'b1000, 4'd0);
      issue(LDB, 4'b0110, 4'd0);
      issue(GO, 4'h0, 4'd2);
`ifdef MATSEQ_CHAIN_EN
      sb.push_back(8'h40);
`else
      sb.push_back(8'h10);
`endif
      wait_done("t4", nexp(2));

      issue(GO, 4'h0, 4'd0);
      sb.push_back(8'h10);
      wait_done("t5_cnt0", 1);

      issue(LDA, 4'b1011, 4'd0);
      issue(GO, 4'h0, 4'd5);
      chk("t5_err_before", 32'(err), 32'd0);
      sb.push_back(chain(4'b1011, 4'b0110, nexp(5)));
      cmd = LDA; data_in = 4'b0000;
      wait_done("t5_mulcmd", nexp(5));
      chk("t5_err_after", 32'(err), 32'd1);
      issue(GO, 4'h0, 4'd1);
      sb.push_back(8'h15);
      wait_done("t5_a_kept", 1);

      issue(GO, 4'h0, 4'd3);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_result", 32'(result), 32'h00);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      issue(GO, 4'h0, 4'd1);
      chk("t6_err_start", 32'(err), 32'd1);
      chk("t6_idle", 32'(busy), 32'd0);

      for (int r = 0; r < 8; r++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 4'($urandom_range(0, 3));
         issue(LDA, ra, 4'd0);
         issue(LDB, rb, 4'd0);
         issue(GO, 4'h0, rc);
         sb.push_back(chain(ra, rb, nexp(int'(rc))));
         wait_done("rnd", nexp(int'(rc)));
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
